path_draw_ctrl: RTL and testbench

Sequencer that renders the tour overlay for the graph display. It walks the visit-order list `path`, takes consecutive point pairs from the `xs`/`ys` coordinate tables, and rasterises each edge with an integer Bresenham stepper. It emits one framebuffer pixel write per cycle over a valid/ready port. It sits between the point/path registers and the framebuffer write arbiter of the VGA graph subsystem.

---
 rtl/path_draw_pkg.sv | 34 +++
 rtl/path_draw_ctrl_line_stepper.sv | 94 +++++++++
 rtl/path_draw_ctrl.sv | 148 ++++++++++++++
 tb/tb_path_draw_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_draw_pkg.sv
// +----------------------------------------------------------------------+
// | path_draw_pkg: shared state encoding, types and colour defaults       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package path_draw_pkg;

  localparam int PD_COORD_W = 8;
  localparam int PD_COLOR_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SETUP = 3'd3,
    STEP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef logic [PD_COORD_W-1:0]        coord_t;
  typedef logic signed [PD_COORD_W+1:0] err_t;

  localparam logic [PD_COLOR_W-1:0] c_line_color = 16'hFFFF;
  localparam logic [PD_COLOR_W-1:0] c_bg_color   = 16'h0000;

  // Number of edges drawn for a given point count and loop mode.
  function automatic int nseg(input int npts, input int close_loop);
    return (close_loop != 0) ? npts : npts - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/path_draw_ctrl_line_stepper.sv
// +----------------------------------------------------------------------+
// | line_stepper: integer Bresenham stepper for one edge                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module line_stepper
  import path_draw_pkg::*;
#(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               setup,
  input  logic               advance,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] c_one = COORD_W'(1);

  logic [COORD_W-1:0]   r_cx, r_cy, r_x1, r_y1;
  logic signed [EW-1:0] r_dx, r_dy, r_err;
  logic                 r_sx_neg, r_sy_neg;

  logic [COORD_W-1:0]   w_adx, w_ady, w_cx_next, w_cy_next;
  logic signed [EW-1:0] w_err_next;
  logic signed [EW:0]   w_e2, w_dx_ext, w_dy_ext;

  // During SETUP the current position still holds the start point.
  assign w_adx = (r_x1 >= r_cx) ? (r_x1 - r_cx) : (r_cx - r_x1);
  assign w_ady = (r_y1 >= r_cy) ? (r_y1 - r_cy) : (r_cy - r_y1);

  assign last = (r_cx == r_x1) && (r_cy == r_y1);
  assign cx   = r_cx;
  assign cy   = r_cy;

  always_comb begin
    w_e2       = {r_err, 1'b0};
    w_dx_ext   = {r_dx[EW-1], r_dx};
    w_dy_ext   = {r_dy[EW-1], r_dy};
    w_err_next = r_err;
    w_cx_next  = r_cx;
    w_cy_next  = r_cy;
    // Both tests use the pre-update error term.
    if (w_e2 >= w_dy_ext) begin
      w_err_next = w_err_next + r_dy;
      w_cx_next  = r_sx_neg ? (r_cx - c_one) : (r_cx + c_one);
    end
    if (w_e2 <= w_dx_ext) begin
      w_err_next = w_err_next + r_dx;
      w_cy_next  = r_sy_neg ? (r_cy - c_one) : (r_cy + c_one);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (load) begin
      r_cx <= x0;
      r_cy <= y0;
      r_x1 <= x1;
      r_y1 <= y1;
    end else if (setup) begin
      r_dx     <= {2'b00, w_adx};
      r_dy     <= '0 - {2'b00, w_ady};
      r_err    <= {2'b00, w_adx} - {2'b00, w_ady};
      r_sx_neg <= (r_x1 < r_cx);
      r_sy_neg <= (r_y1 < r_cy);
    end else if (advance && !last) begin
      r_err <= w_err_next;
      r_cx  <= w_cx_next;
      r_cy  <= w_cy_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/path_draw_ctrl.sv
// +----------------------------------------------------------------------+
// | path_draw_ctrl: walks the tour and streams Bresenham edge pixels.    |
// | Optional PATH_DRAW_CLEAR_EN adds a raster clear pass before drawing. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module path_draw_ctrl
  import path_draw_pkg::*;
#(
  parameter int                  NPTS       = 64,
  parameter int                  COORD_W    = 8,
  parameter int                  COLOR_W    = 16,
  parameter logic [COLOR_W-1:0]  LINE_COLOR = c_line_color,
  parameter logic [COLOR_W-1:0]  BG_COLOR   = c_bg_color,
  parameter int                  CLOSE_LOOP = 1,
  localparam int                 IDX_W      = (NPTS > 1) ? $clog2(NPTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NPTS-1:0][COORD_W-1:0]  xs,
  input  logic [NPTS-1:0][COORD_W-1:0]  ys,
  input  logic [NPTS-1:0][IDX_W-1:0]    path,
  output logic                          busy,
  output logic                          done,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [COORD_W-1:0]            pix_x,
  output logic [COORD_W-1:0]            pix_y,
  output logic [COLOR_W-1:0]            pix_color
);

  localparam int   NSEG     = nseg(NPTS, CLOSE_LOOP);
  localparam logic c_no_seg = (NSEG == 0);

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_seg, w_idx_a, w_idx_b;
  logic               w_accept, w_last, w_seg_more;
  logic [COORD_W-1:0] w_cx, w_cy;

  assign w_accept   = pix_valid && pix_ready;
  assign w_seg_more = (int'(r_seg) + 1) < NSEG;
  assign w_idx_a    = path[r_seg];
  assign w_idx_b    = ((int'(r_seg) + 1) >= NPTS) ? path[0] : path[r_seg + IDX_W'(1)];

`ifdef PATH_DRAW_CLEAR_EN
  logic [2*COORD_W-1:0] r_clr;
  logic                 w_clr_last;

  assign w_clr_last = &r_clr;

  // Wraps back to zero after the last raster pixel, ready for the next draw.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clr <= '0;
    end else if ((r_state == CLEAR) && w_accept) begin
      r_clr <= r_clr + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seg <= '0;
    end else if (r_state == IDLE) begin
      r_seg <= '0;
    end else if ((r_state == STEP) && w_accept && w_last && w_seg_more) begin
      r_seg <= r_seg + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef PATH_DRAW_CLEAR_EN
          w_state_next = CLEAR;
`else
          w_state_next = c_no_seg ? DONE : LOAD;
`endif
        end
      end
`ifdef PATH_DRAW_CLEAR_EN
      CLEAR: begin
        if (w_accept && w_clr_last) begin
          w_state_next = c_no_seg ? DONE : LOAD;
        end
      end
`endif
      LOAD:  w_state_next = SETUP;
      SETUP: w_state_next = STEP;
      STEP: begin
        if (w_accept && w_last) begin
          w_state_next = w_seg_more ? LOAD : DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    pix_valid = (r_state == STEP);
    pix_x     = w_cx;
    pix_y     = w_cy;
    pix_color = (r_state == STEP) ? LINE_COLOR : '0;
`ifdef PATH_DRAW_CLEAR_EN
    if (r_state == CLEAR) begin
      pix_valid = 1'b1;
      pix_x     = r_clr[COORD_W-1:0];
      pix_y     = r_clr[2*COORD_W-1:COORD_W];
      pix_color = BG_COLOR;
    end
`endif
  end

  line_stepper #(
    .COORD_W (COORD_W)
  ) u_stepper (
    .clk     (clk),
    .rst     (rst),
    .load    (r_state == LOAD),
    .setup   (r_state == SETUP),
    .advance ((r_state == STEP) && w_accept),
    .x0      (xs[w_idx_a]),
    .y0      (ys[w_idx_a]),
    .x1      (xs[w_idx_b]),
    .y1      (ys[w_idx_b]),
    .cx      (w_cx),
    .cy      (w_cy),
    .last    (w_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_path_draw_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_path_draw_ctrl: randomized scoreboard bench for path_draw_ctrl    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_path_draw_ctrl;

  localparam int          NPTS  = 4;
  localparam int          CW    = 8;
  localparam int          COLW  = 16;
  localparam int          CLOSE = 1;
  localparam logic [15:0] LC    = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic pix_ready = 1'b1;
  logic [NPTS-1:0][CW-1:0] xs, ys;
  logic [NPTS-1:0][1:0]    path;
  logic            busy, done, pix_valid;
  logic [CW-1:0]   pix_x, pix_y;
  logic [COLW-1:0] pix_color;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  path_draw_ctrl #(
    .NPTS       (NPTS),
    .COORD_W    (CW),
    .COLOR_W    (COLW),
    .LINE_COLOR (LC),
    .BG_COLOR   (16'h0000),
    .CLOSE_LOOP (CLOSE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .xs        (xs),
    .ys        (ys),
    .path      (path),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: each edge is the Bresenham pixel list from its endpoints,
  // edges in path order, followed by one completion marker.
  task automatic build_model();
    int nseg = (CLOSE != 0) ? NPTS : NPTS - 1;
    for (int s = 0; s < nseg; s++) begin
      int a = int'(path[s]);
      int b = int'(path[(s + 1) % NPTS]);
      int x = int'(xs[a]), y = int'(ys[a]);
      int x1 = int'(xs[b]), y1 = int'(ys[b]);
      int dx = (x1 > x) ? x1 - x : x - x1;
      int dy = -((y1 > y) ? y1 - y : y - y1);
      int sx = (x1 > x) ? 1 : -1;
      int sy = (y1 > y) ? 1 : -1;
      int err = dx + dy;
      int guard = 0;
      while (guard < 1024) begin
        int e2;
        q.push_back('{1'b0, x, y, int'(LC)});
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
        guard++;
      end
    end
    q.push_back('{1'b1, 0, 0, 0});
  endtask

  // Ready driver: always ready for directed timing, random otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted pixel and on done.
  initial begin
    bit              prev_stall = 1'b0;
    logic [CW-1:0]   px, py;
    logic [COLW-1:0] pc;
    exp_t            e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", int'(pix_valid), 1);
          check("stall_x_held", int'(pix_x), int'(px));
          check("stall_y_held", int'(pix_y), int'(py));
          check("stall_color_held", int'(pix_color), int'(pc));
        end
        if (pix_valid && pix_ready) begin
          if (q.size() == 0) begin
            check("unexpected_pixel", 1, 0);
          end else begin
            e = q.pop_front();
            check("pixel_not_done_marker", int'(e.is_done), 0);
            check("pix_x", int'(pix_x), e.x);
            check("pix_y", int'(pix_y), e.y);
            check("pix_color", int'(pix_color), e.c);
          end
        end
        if (done) begin
          check("done_without_valid", int'(pix_valid), 0);
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("done_after_last_pixel", int'(e.is_done), 1);
          end
        end
        prev_stall = pix_valid && !pix_ready;
        px = pix_x;
        py = pix_y;
        pc = pix_color;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("draw_completes_in_budget", int'(n < budget), 1);
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(pix_valid), 0);
    check({tag, "_x"}, int'(pix_x), 0);
    check({tag, "_y"}, int'(pix_y), 0);
    check({tag, "_color"}, int'(pix_color), 0);
  endtask

  task automatic set_square();
    xs[0] = 8'd0; ys[0] = 8'd0;
    xs[1] = 8'd3; ys[1] = 8'd0;
    xs[2] = 8'd3; ys[2] = 8'd3;
    xs[3] = 8'd0; ys[3] = 8'd3;
    for (int i = 0; i < NPTS; i++) path[i] = 2'(i);
  endtask

  initial begin
    int n;
    set_square();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();

    // Square, always ready: exact cycle timing of valid and done.
    rand_ready = 1'b0;
    build_model();
    start = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      bit exp_v;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      exp_v = (c >= 3 && c <= 6) || (c >= 9 && c <= 12) ||
              (c >= 15 && c <= 18) || (c >= 21 && c <= 24);
      check($sformatf("timing_valid_c%0d", c), int'(pix_valid), int'(exp_v));
      check($sformatf("timing_done_c%0d", c), int'(done), int'(c == 25));
    end
    tick();
    wait_idle(200);

    // Square with random backpressure.
    rand_ready = 1'b1;
    build_model();
    pulse_start();
    wait_idle(2000);

    // Reset during the third pixel of the second edge.
    rand_ready = 1'b0;
    tick();
    build_model();
    pulse_start();
    repeat (10) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      check("midreset_no_done", int'(done), 0);
    end
    tick();
    build_model();
    pulse_start();
    wait_idle(200);

    // All points identical, extra start while busy.
    rand_ready = 1'b1;
    for (int i = 0; i < NPTS; i++) begin
      xs[i] = 8'd5;
      ys[i] = 8'd7;
      path[i] = 2'($urandom_range(0, NPTS - 1));
    end
    build_model();
    pulse_start();
    repeat (4) tick();
    pulse_start();
    wait_idle(500);

    // Start raised during the DONE cycle is ignored.
    build_model();
    pulse_start();
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    check("done_seen_in_budget", int'(n < 500), 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("start_in_done_ignored", int'(busy), 0);
      tick();
    end
    q.delete();

    // Randomized tours, some with short edges and repeated indices.
    for (int it = 0; it < 15; it++) begin
      int hi = (it % 3 == 0) ? 255 : ((it % 3 == 1) ? 15 : 3);
      for (int i = 0; i < NPTS; i++) begin
        xs[i] = 8'($urandom_range(0, hi));
        ys[i] = 8'($urandom_range(0, hi));
        path[i] = 2'($urandom_range(0, NPTS - 1));
      end
      build_model();
      pulse_start();
      wait_idle(6000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
